// File: rtl/seq_mult_if.sv
// Operand/result handshake bundle for the sequential shift-add multiplier.
// The master drives operands and takes the product; the slave is the multiplier core.
interface seq_mult_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, signed_mode, multiplicand, multiplier, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, signed_mode, multiplicand, multiplier, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/seq_mult_core.sv
// Sequential shift-add multiplier (one multiplier bit per cycle) with sign-magnitude signed mode.
// Optional macro SEQ_MULT_EARLY_EXIT_EN ends CALC once the remaining multiplier bits are all zero.
module seq_mult_core #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  seq_mult_if.slave  bus
);
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PW-1:0]      mcand;
  logic [WIDTH-1:0]   mplier;
  logic [PW-1:0]      acc;
  logic [CNT_W-1:0]   cnt;
  logic               sign;
  logic               zero_op;
  logic [PW-1:0]      product_r;
  logic [PW-1:0]      acc_nxt;
  logic               last_iter;

  // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1) without overflow.
  function automatic logic [WIDTH-1:0] abs_op(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag, input logic neg);
    return neg ? (~mag + PW'(1)) : mag;
  endfunction

  always_comb begin
    acc_nxt = mplier[0] ? (acc + mcand) : acc;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    last_iter = (mplier[WIDTH-1:1] == '0) || (cnt == CNT_W'(WIDTH - 1));
`else
    last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)           state_nxt = CALC;
      CALC:    if (zero_op || last_iter)   state_nxt = DONE;
      DONE:    if (bus.out_ready)          state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      zero_op   <= 1'b0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          mcand   <= {{WIDTH{1'b0}}, abs_op(bus.multiplicand, bus.signed_mode)};
          mplier  <= abs_op(bus.multiplier, bus.signed_mode);
          acc     <= '0;
          cnt     <= '0;
          sign    <= bus.signed_mode & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
          zero_op <= (bus.multiplicand == '0) || (bus.multiplier == '0);
        end
        CALC: if (zero_op) begin
          product_r <= '0;
        end else begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) product_r <= apply_sign(acc_nxt, sign);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.product   = product_r;
endmodule

// File: tb/tb_seq_mult_core.sv
// Scoreboard bench for seq_mult_core at WIDTH = 16: expected products queued on issue, popped on out_valid.
module tb_seq_mult_core;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(W)) bus();
  seq_mult_core #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic s);
    longint pa, pb;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end else begin
      pa = longint'(a);
      pb = longint'(b);
    end
    return (2*W)'(pa * pb);
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] m;
    int hi;
    if (a == '0 || b == '0) return 1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    m = (s && b[W-1]) ? -b : b;
    hi = 0;
    for (int i = 0; i < W; i++) if (m[i]) hi = i;
    return hi + 1;
`else
    m = '0;
    hi = 0;
    return W + int'(m) + hi;
`endif
  endfunction

  // Issue one pair, check latency and product, optionally stall the consumer, then release.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [2*W-1:0] expv, input int exp_lat,
                        input int hold);
    int lat;
    logic [2*W-1:0] held;
    exp_q.push_back(expv);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.signed_mode  = s;
    bus.in_valid     = 1'b1;
    @(posedge clk); #1;
    bus.in_valid     = 1'b0;
    bus.multiplicand = W'($urandom);
    bus.multiplier   = W'($urandom);
    bus.signed_mode  = ~s;
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (exp_q.size() == 0) chk({tag, "_queue_empty"}, 64'd0, 64'd1);
    else chk({tag, "_product"}, 64'(bus.product), 64'(exp_q.pop_front()));
    held = bus.product;
    for (int i = 0; i < hold; i++) begin
      bus.multiplicand = 16'h0011;
      bus.multiplier   = 16'h0022;
      bus.in_valid     = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_hold_product"}, 64'(bus.product), 64'(held));
      chk({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_release_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_release_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic rs;
    int seen;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.signed_mode  = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_product",   64'(bus.product),   64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("u_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, model_lat(16'hFFFF, 16'hFFFF, 1'b0), 0);
    run_op("s_fffd_5",    16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, model_lat(16'hFFFD, 16'h0005, 1'b1), 0);
    run_op("s_8000_8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000, model_lat(16'h8000, 16'h8000, 1'b1), 0);
    run_op("u_8000_2",    16'h8000, 16'h0002, 1'b0, 32'h00010000, model_lat(16'h8000, 16'h0002, 1'b0), 0);
    run_op("zero_a",      16'h0000, 16'h1234, 1'b0, 32'h00000000, 1, 0);
    run_op("zero_b_sgn",  16'hFFFF, 16'h0000, 1'b1, 32'h00000000, 1, 0);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    run_op("u_3_7",       16'h0003, 16'h0007, 1'b0, 32'h00000015, 3, 0);
`else
    run_op("u_3_7",       16'h0003, 16'h0007, 1'b0, 32'h00000015, 16, 0);
`endif
    run_op("hold_stall",  16'h1234, 16'h5678, 1'b0, 32'h06260060, model_lat(16'h1234, 16'h5678, 1'b0), 5);

    for (int k = 0; k < 6; k++) begin
      ra = W'($urandom);
      rb = W'($urandom >> (k * 2));
      rs = 1'($urandom);
      run_op($sformatf("rand%0d", k), ra, rb, rs, model_prod(ra, rb, rs), model_lat(ra, rb, rs), 0);
    end

    // Abort a pair in the middle of CALC; no result may appear for it.
    bus.multiplicand = 16'hFFFF;
    bus.multiplier   = 16'hFFFF;
    bus.signed_mode  = 1'b0;
    bus.in_valid     = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_product",   64'(bus.product),   64'd0);
    chk("abort_in_ready",  64'(bus.in_ready),  64'd1);
    chk("abort_busy",      64'(bus.busy),      64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("abort_no_result", 64'(seen), 64'd0);
    run_op("after_abort_3_4", 16'h0003, 16'h0004, 1'b0, 32'h0000000C, model_lat(16'h0003, 16'h0004, 1'b0), 0);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
